// File: rtl/logic_unit_rr_arbiter_if.sv
// Request/response bundle for the shared logic-unit arbiter.
// The slave side is the arbiter; the master side drives requests and consumes results.
interface logic_unit_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/logic_unit_rr_arbiter.sv
// Round-robin arbiter sharing one bitwise AND/OR/XOR/NOR unit between NUM_REQ
// requesters, with a registered result and one operation in flight.
module logic_unit_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input logic                     clk,
    input logic                     reset,
    logic_unit_rr_arbiter_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [WIDTH-1:0]   rsp_result_r;

    logic               can_accept_s;
    logic               grant_valid_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               transfer_s;
    logic [1:0]         sel_op_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned ofs);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W+1)'(ofs);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            2'b11:   return ~(a | b);
            default: return {WIDTH{1'b0}};
        endcase
    endfunction

    assign can_accept_s = (state_r == IDLE) || bus.rsp_ready;

    // Pick the first valid requester at or after rr_ptr, wrapping upward
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid_s && bus.req_valid[wrap_idx(rr_ptr_r, k)]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = wrap_idx(rr_ptr_r, k);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // One-hot accept, suppressed during reset and under backpressure
    always_comb begin
        ready_s = '0;
        if (!reset && can_accept_s && grant_valid_s) begin
            ready_s[grant_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign transfer_s = |(ready_s & bus.req_valid);

    // Operand/op mux for the granted requester
    always_comb begin
        sel_op_s = 2'b00;
        sel_a_s  = '0;
        sel_b_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx_s == ID_W'(k)) begin
                sel_op_s = bus.req_op[2*k +: 2];
                sel_a_s  = bus.req_a[WIDTH*k +: WIDTH];
                sel_b_s  = bus.req_b[WIDTH*k +: WIDTH];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    // Response FSM: a transfer always (re)loads the result, even back-to-back
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            rr_ptr_r     <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
        end else begin
            case (state_r)
                IDLE, RESP: begin
                    if (transfer_s) begin
                        state_r      <= RESP;
                        rsp_valid_r  <= 1'b1;
                        rsp_id_r     <= grant_idx_s;
                        rsp_result_r <= logic_op(sel_op_s, sel_a_s, sel_b_s);
                        rr_ptr_r     <= wrap_idx(grant_idx_s, 1);
                    end else if (state_r == RESP && bus.rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
endmodule

// File: tb/tb_logic_unit_rr_arbiter.sv
// Directed bench for logic_unit_rr_arbiter: a vector table of single
// transfers plus hand-written round-robin, backpressure and reset sequences.
module tb_logic_unit_rr_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic_unit_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

    logic_unit_rr_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp3[4];
    logic [3:0]  one;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_slot(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[2*i +: 2] = op;
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        one   = 4'b0001;
        vecs[0] = '{0, 2'b01, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF};
        vecs[1] = '{1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000};
        vecs[2] = '{2, 2'b10, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987};
        vecs[3] = '{3, 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[4] = '{0, 2'b11, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F};
        vecs[5] = '{1, 2'b10, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000};
        exp3[0] = 32'h55555555;
        exp3[1] = 32'hFFFFFFFF;
        exp3[2] = 32'hAAAAAAAA;
        exp3[3] = 32'h00000000;

        // Reset with all requesters valid: nothing may be accepted
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rsp_result", bus.rsp_result, 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        bus.req_valid = 4'b0000;
        reset = 1'b0;

        // Table of single transfers
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            drive_slot(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b);
            bus.req_valid = one << vecs[v].idx;
            bus.rsp_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(one << vecs[v].idx));
            @(negedge clk);
            bus.req_valid = 4'b0000;
            #1;
            check($sformatf("vec%0d_valid", v), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("vec%0d_id", v), 32'(bus.rsp_id), 32'(vecs[v].idx));
            check($sformatf("vec%0d_result", v), bus.rsp_result, vecs[v].exp);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_idle", v), 32'(bus.rsp_valid), 32'd0);
        end

        // All four held valid: grants rotate 0,1,2,3,0 at one op per cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_slot(i, 2'(i), 32'hFFFFFFFF, 32'h55555555);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req_valid = 4'b1111;
            #1;
            check($sformatf("rr%0d_ready", c), 32'(bus.req_ready), 32'(one << (c % 4)));
            if (c > 0) begin
                check($sformatf("rr%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
                check($sformatf("rr%0d_id", c), 32'(bus.rsp_id), 32'((c - 1) % 4));
                check($sformatf("rr%0d_result", c), bus.rsp_result, exp3[(c - 1) % 4]);
            end
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("rr_last_id", 32'(bus.rsp_id), 32'd0);
        check("rr_last_result", bus.rsp_result, 32'h55555555);
        @(negedge clk);
        #1;
        check("rr_idle", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: result held, no accepts until rsp_ready rises
        do_reset();
        drive_slot(2, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive_slot(1, 2'b01, 32'h00000001, 32'h00000002);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_first_ready", 32'(bus.req_ready), 32'b0100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.req_valid = 4'b0010;
            #1;
            check($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp%0d_id", c), 32'(bus.rsp_id), 32'd2);
            check($sformatf("bp%0d_result", c), bus.rsp_result, 32'h00000000);
            check($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.req_ready), 32'b0010);
        check("bp_release_id", 32'(bus.rsp_id), 32'd2);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_next_id", 32'(bus.rsp_id), 32'd1);
        check("bp_next_result", bus.rsp_result, 32'h00000003);
        @(negedge clk);
        #1;
        check("bp_idle", 32'(bus.rsp_valid), 32'd0);

        // Reset while a result is pending clears it and the pointer
        drive_slot(2, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        #1;
        check("rst_pre_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("rst_pre_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 4'b1001;
        #1;
        check("rst_during_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_after_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_after_result", bus.rsp_result, 32'd0);
        check("rst_after_id", 32'(bus.rsp_id), 32'd0);
        check("rst_after_ptr_grant", 32'(bus.req_ready), 32'b0001);
        bus.rsp_ready = 1'b1;
        drive_slot(3, 2'b11, 32'h0000FFFF, 32'h00FF0000);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        check("rst_req3_ready", 32'(bus.req_ready), 32'b1000);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("rst_req3_id", 32'(bus.rsp_id), 32'd3);
        check("rst_req3_result", bus.rsp_result, 32'hFF000000);
        @(negedge clk);
        #1;
        check("rst_idle", 32'(bus.rsp_valid), 32'd0);

        // Wrap: pointer at 3, only req1 valid -> grant 1, pointer moves to 2
        @(negedge clk);
        bus.req_valid = 4'b0100;
        #1;
        check("wrap_setup_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        check("wrap_grant1", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = 4'b1110;
        #1;
        check("wrap_ptr2_grant", 32'(bus.req_ready), 32'b0100);
        check("wrap_rsp_id", 32'(bus.rsp_id), 32'd1);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("wrap_last_id", 32'(bus.rsp_id), 32'd2);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
